// File: rtl/mips_pkg.sv
// Shared definitions for the store buffer: control states and default geometry.
package mips_pkg;

  localparam int unsigned SB_DEPTH_DEF = 4;
  localparam int unsigned SB_AW_DEF    = 8;
  localparam int unsigned SB_DW        = 16;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sb_state_e;

endpackage

// File: rtl/store_buffer_if.sv
// Core-side and data-memory-side signals of the store buffer, bundled as one bus.
interface store_buffer_if
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEF
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic [SB_DW-1:0]  st_addr;
  logic [SB_DW-1:0]  st_data;
  logic              st_ready;
  logic              ld_req;
  logic [SB_DW-1:0]  ld_addr;
  logic [SB_DW-1:0]  ld_data;
  logic              ld_fwd;
  logic              flush_req;
  logic              flush_done;
  logic [SB_DW-1:0]  mem_addr;
  logic [SB_DW-1:0]  mem_write;
  logic              mem_write_en;
  logic              mem_read;
  logic [SB_DW-1:0]  mem_read_data;
  logic [CW-1:0]     count;

  modport slave (
    input  st_valid, st_addr, st_data, ld_req, ld_addr, flush_req, mem_read_data,
    output st_ready, ld_data, ld_fwd, flush_done, mem_addr, mem_write,
           mem_write_en, mem_read, count
  );

  modport master (
    output st_valid, st_addr, st_data, ld_req, ld_addr, flush_req, mem_read_data,
    input  st_ready, ld_data, ld_fwd, flush_done, mem_addr, mem_write,
           mem_write_en, mem_read, count
  );

endinterface

// File: rtl/sb_match.sv
// Youngest-match selector: entries arrive ordered oldest (0) to youngest (DEPTH-1).
module sb_match #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 16
) (
  input  logic [AW-1:0]    i_key,
  input  logic [AW-1:0]    i_tag   [DEPTH],
  input  logic [DEPTH-1:0] i_valid,
  input  logic [DW-1:0]    i_data  [DEPTH],
  output logic             o_hit,
  output logic [DW-1:0]    o_data
);

  // Later (younger) hits override earlier ones.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (i_valid[k] && (i_tag[k] == i_key)) begin
        o_hit  = 1'b1;
        o_data = i_data[k];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer with load forwarding, load-priority memory port and flush.
module store_buffer
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEF,
  parameter int unsigned AW    = SB_AW_DEF
) (
  input logic           clk,
  input logic           rst_n,
  store_buffer_if.slave sb
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = SB_DW;

  logic [DW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  sb_state_e        r_state;
  logic             r_flush_done;

  logic             w_ready;
  logic             w_accept;
  logic             w_drain;
  logic [CW-1:0]    w_count_nxt;
  logic [AW-1:0]    w_tag   [DEPTH];
  logic [DW-1:0]    w_odata [DEPTH];
  logic [DEPTH-1:0] w_ovalid;
  logic             w_hit;
  logic [DW-1:0]    w_fwd_data;

  assign w_ready  = (r_count < CW'(DEPTH)) && (r_state == RUN);
  assign w_accept = sb.st_valid & w_ready;
  assign w_drain  = (r_count != '0) & ~sb.ld_req;

  always_comb begin
    w_count_nxt = r_count;
    if (w_accept && !w_drain) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_accept && w_drain) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Present entries in age order so the selector only needs "last hit wins".
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_tag[k]    = r_addr[r_head + PW'(k)][AW-1:0];
      w_odata[k]  = r_data[r_head + PW'(k)];
      w_ovalid[k] = (CW'(k) < r_count);
    end
  end

  sb_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_match (
    .i_key   (sb.ld_addr[AW-1:0]),
    .i_tag   (w_tag),
    .i_valid (w_ovalid),
    .i_data  (w_odata),
    .o_hit   (w_hit),
    .o_data  (w_fwd_data)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr[r_tail] <= sb.st_addr;
      r_data[r_tail] <= sb.st_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_state      <= RUN;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      r_count      <= w_count_nxt;
      if (w_accept) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_drain) begin
        r_head <= r_head + PW'(1);
      end
      case (r_state)
        RUN: begin
          if (sb.flush_req) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (w_count_nxt == '0) begin
            r_state      <= RUN;
            r_flush_done <= 1'b1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  always_comb begin
    sb.mem_read     = sb.ld_req;
    sb.mem_write_en = w_drain;
    sb.mem_addr     = '0;
    sb.mem_write    = '0;
    sb.ld_data      = '0;
    sb.ld_fwd       = 1'b0;
    if (sb.ld_req) begin
      sb.mem_addr = sb.ld_addr;
      sb.ld_fwd   = w_hit;
      sb.ld_data  = w_hit ? w_fwd_data : sb.mem_read_data;
    end else if (w_drain) begin
      sb.mem_addr  = r_addr[r_head];
      sb.mem_write = r_data[r_head];
    end
  end

  assign sb.st_ready   = w_ready;
  assign sb.count      = r_count;
  assign sb.flush_done = r_flush_done;

endmodule

// File: tb/tb_store_buffer.sv
// Directed and randomized checks of store_buffer against a queue-based reference model.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH)) sbif ();

  store_buffer #(.DEPTH(DEPTH), .AW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sbif.slave)
  );

  logic [15:0] ram   [65536];
  logic [15:0] m_ram [65536];
  assign sbif.mem_read_data = ram[sbif.mem_addr];

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } ent_t;

  ent_t q[$];
  bit   m_fl;
  bit   m_fd;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, check against the model, then advance.
  task automatic step(input bit sv, input logic [15:0] sa, input logic [15:0] sd,
                      input bit lr, input logic [15:0] la, input bit fr);
    int          sz;
    bit          rdy, acc, dr, hit;
    logic [15:0] fd, e_addr, e_wr, e_ld;
    bit          o_we;
    logic [15:0] o_a, o_d;
    sbif.st_valid  = sv;
    sbif.st_addr   = sa;
    sbif.st_data   = sd;
    sbif.ld_req    = lr;
    sbif.ld_addr   = la;
    sbif.flush_req = fr;
    #1;
    sz  = q.size();
    rdy = (sz < DEPTH) && !m_fl;
    acc = sv && rdy;
    dr  = (sz > 0) && !lr;
    hit = 1'b0;
    fd  = '0;
    for (int i = 0; i < sz; i++) begin
      if (q[i].a[7:0] == la[7:0]) begin
        hit = 1'b1;
        fd  = q[i].d;
      end
    end
    e_addr = lr ? la : (dr ? q[0].a : 16'h0);
    e_wr   = dr ? q[0].d : 16'h0;
    e_ld   = lr ? (hit ? fd : m_ram[la]) : 16'h0;
    chk("count",        32'(sbif.count),  32'(sz));
    chk("st_ready",     32'(sbif.st_ready), 32'(rdy));
    chk("mem_write_en", 32'(sbif.mem_write_en), 32'(dr));
    chk("mem_read",     32'(sbif.mem_read), 32'(lr));
    chk("mem_addr",     32'(sbif.mem_addr), 32'(e_addr));
    chk("mem_write",    32'(sbif.mem_write), 32'(e_wr));
    chk("ld_data",      32'(sbif.ld_data), 32'(e_ld));
    chk("ld_fwd",       32'(sbif.ld_fwd), 32'(lr && hit));
    chk("flush_done",   32'(sbif.flush_done), 32'(m_fd));
    o_we = sbif.mem_write_en;
    o_a  = sbif.mem_addr;
    o_d  = sbif.mem_write;
    @(posedge clk);
    if (o_we) ram[o_a] = o_d;
    if (dr) begin
      m_ram[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (acc) q.push_back('{a: sa, d: sd});
    m_fd = 1'b0;
    if (!m_fl) begin
      if (fr) m_fl = 1'b1;
    end else if (q.size() == 0) begin
      m_fl = 1'b0;
      m_fd = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'h0, 16'h0, 0, 16'h0, 0);
  endtask

  task automatic do_reset();
    sbif.st_valid  = 1'b0;
    sbif.ld_req    = 1'b0;
    sbif.flush_req = 1'b0;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_fl = 1'b0;
    m_fd = 1'b0;
    chk("rst_count",      32'(sbif.count), 32'd0);
    chk("rst_write_en",   32'(sbif.mem_write_en), 32'd0);
    chk("rst_flush_done", 32'(sbif.flush_done), 32'd0);
    chk("rst_st_ready",   32'(sbif.st_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]   = 16'(i * 7) ^ 16'h5A5A;
      m_ram[i] = 16'(i * 7) ^ 16'h5A5A;
    end
    sbif.st_valid  = 1'b0;
    sbif.st_addr   = '0;
    sbif.st_data   = '0;
    sbif.ld_req    = 1'b0;
    sbif.ld_addr   = '0;
    sbif.flush_req = 1'b0;
    @(negedge clk);
    do_reset();

    // Single store drains on the following edge
    step(1, 16'd7, 16'h1234, 0, 16'h0, 0);
    step(0, 16'h0, 16'h0, 0, 16'h0, 0);
    chk("ram7", 32'(ram[7]), 32'h1234);

    // Fill while loads hold the port, fifth store stalls, then in-order drain
    for (int i = 1; i <= 5; i++) step(1, 16'(i), 16'(16'h1000 + i), 1, 16'h00F0, 0);
    chk("full_count", 32'(sbif.count), 32'd4);
    chk("full_ready", 32'(sbif.st_ready), 32'd0);
    idle(4);
    for (int i = 1; i <= 4; i++) chk("drain_ram", 32'(ram[i]), 32'(16'h1000 + i));
    chk("drained_ram5", 32'(ram[5]), 32'(16'(5 * 7) ^ 16'h5A5A));

    // Youngest-match forwarding, including the AW alias
    step(1, 16'd5, 16'hAAAA, 1, 16'h00F0, 0);
    step(1, 16'd5, 16'hBBBB, 1, 16'h00F0, 0);
    step(0, 16'h0, 16'h0, 1, 16'h0005, 0);
    step(0, 16'h0, 16'h0, 1, 16'h0105, 0);
    idle(3);
    chk("ram5", 32'(ram[5]), 32'hBBBB);

    // Load miss reads memory
    step(0, 16'h0, 16'h0, 1, 16'd9, 0);

    // Flush with three buffered stores; repeat flush_req inside FLUSH is ignored
    for (int i = 0; i < 3; i++) step(1, 16'(16'h20 + i), 16'(16'hC000 + i), 1, 16'h00F0, 0);
    step(0, 16'h0, 16'h0, 1, 16'h00F0, 1);
    step(1, 16'h30, 16'hDEAD, 1, 16'h00F0, 0);
    step(0, 16'h0, 16'h0, 0, 16'h0, 1);
    idle(5);

    // Reset in the middle of a flush
    for (int i = 0; i < 3; i++) step(1, 16'(16'h40 + i), 16'(16'hE000 + i), 1, 16'h00F0, 0);
    step(0, 16'h0, 16'h0, 1, 16'h00F0, 1);
    do_reset();
    idle(4);
    chk("abort_ram40", 32'(ram[16'h40]), 32'(16'(16'h40 * 7) ^ 16'h5A5A));

    // Random traffic over a small aliasing address set
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 1) == 1,
           {8'($urandom_range(0, 1)), 8'($urandom_range(0, 7))},
           16'($urandom),
           $urandom_range(0, 2) == 0,
           {8'($urandom_range(0, 1)), 8'($urandom_range(0, 7))},
           $urandom_range(0, 29) == 0);
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
